// File: rtl/axicb_ecc_pkg.sv
`default_nettype none
// axicb_ecc_pkg -- SECDED Hamming(39,32)+overall parity codec, AXI response codes, responder FSM states.
// Rev 1.0
package axicb_ecc_pkg;

  localparam int ECC_CW_W = 39;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic        single_err;
    logic        double_err;
  } ecc_dec_t;

  typedef enum logic [1:0] {W_IDLE, W_RMW, W_WRITE, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} rd_state_e;

  // Bit 0 is overall parity; bits 1..38 are Hamming positions with check bits at powers of two.
  function automatic logic [ECC_CW_W-1:0] ecc_encode(input logic [31:0] data);
    logic [ECC_CW_W-1:0] cw;
    int j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < ECC_CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = data[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p < ECC_CW_W; p++) begin
        if (((p >> k) & 1) != 0) par ^= cw[p];
      end
      cw[1 << k] = par;
    end
    cw[0] = ^cw[ECC_CW_W-1:1];
    return cw;
  endfunction

  // Odd overall parity means one flipped bit (the syndrome locates it); even parity with a
  // non-zero syndrome means two. On a double error the data is returned uncorrected.
  function automatic ecc_dec_t ecc_decode(input logic [ECC_CW_W-1:0] cw);
    ecc_dec_t            res;
    logic [ECC_CW_W-1:0] fix;
    logic [5:0]          syn;
    logic                overall;
    int                  j;
    syn = '0;
    for (int p = 1; p < ECC_CW_W; p++) begin
      if (cw[p]) syn ^= 6'(p);
    end
    overall = ^cw;
    fix     = cw;
    if (overall && (syn < 6'(ECC_CW_W))) fix[syn] = ~fix[syn];
    res.data = '0;
    j = 0;
    for (int p = 1; p < ECC_CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        res.data[j] = fix[p];
        j++;
      end
    end
    res.single_err = overall;
    res.double_err = !overall && (syn != '0);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axicb_ecc_ram.sv
`default_nettype none
// axicb_ecc_ram -- single-port codeword array, synchronous read with one cycle latency.
// Rev 1.0
module axicb_ecc_ram
  import axicb_ecc_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int WIDTH  = ECC_CW_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axicb_ecc_slv_responder.sv
`default_nettype none
// axicb_ecc_slv_responder -- AXI4-lite slave over a SECDED word array with error injection and counters.
// Rev 1.0
module axicb_ecc_slv_responder
  import axicb_ecc_pkg::*;
#(
  parameter int                    AXI_ADDR_W = 32,
  parameter int                    AXI_ID_W   = 8,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [AXI_ADDR_W-1:0] awaddr,
  input  logic [AXI_ID_W-1:0]   awid,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [AXI_ID_W-1:0]   bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [AXI_ADDR_W-1:0] araddr,
  input  logic [AXI_ID_W-1:0]   arid,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [AXI_ID_W-1:0]   rid,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  input  logic                  inj_valid,
  input  logic [ECC_CW_W-1:0]   inj_mask,
  output logic [15:0]           ce_cnt,
  output logic [15:0]           ue_cnt
);

  localparam int                  IDX_W = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_W:0] SPAN  = (AXI_ADDR_W+1)'(4 * MEM_DEPTH);

  // One extra bit so an address below BASE_ADDR wraps to a huge offset and fails the span test.
  function automatic logic [AXI_ADDR_W:0] addr_off(input logic [AXI_ADDR_W-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_W-1:0] a);
    logic [AXI_ADDR_W:0] off;
    off = addr_off(a);
    return off[IDX_W+1:2];
  endfunction

  wr_state_e             wst_q, wst_d;
  rd_state_e             rst_q, rst_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AXI_ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [AXI_ID_W-1:0]   awid_q, awid_d, arid_q, arid_d, bid_q, bid_d, rid_q, rid_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  rd_issued_q, rd_issued_d;
  logic                  inj_armed_q, inj_armed_d;
  logic [ECC_CW_W-1:0]   inj_mask_q, inj_mask_d;
  logic [15:0]           ce_q, ce_d, ue_q, ue_d;

  logic                  wr_own, wr_we, wr_ce, wr_ue, rd_req, rd_ce, rd_ue;
  logic [IDX_W-1:0]      rd_addr;
  logic [ECC_CW_W-1:0]   wr_cw, ram_rdata;
  logic [31:0]           merged;
  ecc_dec_t              ram_dec;
  logic [16:0]           ce_sum, ue_sum;

  assign wr_own  = (wst_q == W_RMW) || (wst_q == W_WRITE);
  assign ram_dec = ecc_decode(ram_rdata);

  always_comb begin
    merged = wdata_q;
    for (int b = 0; b < 4; b++) begin
      if (!wstrb_q[b]) merged[8*b +: 8] = ram_dec.data[8*b +: 8];
    end
  end

  // Write FSM. The old word requested in W_RMW is on the RAM output during W_WRITE.
  always_comb begin
    wst_d     = wst_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    awid_d    = awid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wr_we     = 1'b0;
    wr_ce     = 1'b0;
    wr_ue     = 1'b0;
    wr_cw     = ecc_encode(merged) ^ (inj_armed_q ? inj_mask_q : '0);
    case (wst_q)
      W_IDLE: begin
        if (awvalid && !aw_held_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
          awid_d    = awid;
        end
        if (wvalid && !w_held_q) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if (addr_off(awaddr_d) >= SPAN) begin
            bresp_d = RESP_DECERR;
            bid_d   = awid_d;
            wst_d   = W_RESP;
          end else if (wstrb_d == 4'hF) begin
            wst_d = W_WRITE;
          end else begin
            wst_d = W_RMW;
          end
        end
      end
      W_RMW:   wst_d = W_WRITE;
      W_WRITE: begin
        bid_d = awid_q;
        wst_d = W_RESP;
        if ((wstrb_q != 4'hF) && ram_dec.double_err) begin
          bresp_d = RESP_SLVERR;
          wr_ue   = 1'b1;
        end else begin
          bresp_d = RESP_OKAY;
          wr_we   = 1'b1;
          wr_ce   = (wstrb_q != 4'hF) && ram_dec.single_err;
        end
      end
      W_RESP: if (bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // Read FSM. The array read is launched on the AR handshake when the port is free, else retried in R_READ.
  always_comb begin
    rst_d       = rst_q;
    arid_d      = arid_q;
    araddr_d    = araddr_q;
    rd_issued_d = rd_issued_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_req      = 1'b0;
    rd_addr     = addr_idx(araddr_q);
    rd_ce       = 1'b0;
    rd_ue       = 1'b0;
    case (rst_q)
      R_IDLE: begin
        if (arvalid) begin
          arid_d   = arid;
          araddr_d = araddr;
          if (addr_off(araddr) >= SPAN) begin
            rid_d   = arid;
            rdata_d = '0;
            rresp_d = RESP_DECERR;
            rst_d   = R_RESP;
          end else begin
            rd_req      = 1'b1;
            rd_addr     = addr_idx(araddr);
            rd_issued_d = !wr_own;
            rst_d       = R_READ;
          end
        end
      end
      R_READ: begin
        if (rd_issued_q) begin
          rid_d       = arid_q;
          rdata_d     = ram_dec.data;
          rresp_d     = ram_dec.double_err ? RESP_SLVERR : RESP_OKAY;
          rd_ce       = ram_dec.single_err;
          rd_ue       = ram_dec.double_err;
          rd_issued_d = 1'b0;
          rst_d       = R_RESP;
        end else begin
          rd_req      = 1'b1;
          rd_issued_d = !wr_own;
        end
      end
      R_RESP:  if (rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    inj_armed_d = inj_armed_q;
    inj_mask_d  = inj_mask_q;
    if (wr_we) inj_armed_d = 1'b0;
    if (inj_valid) begin
      inj_armed_d = 1'b1;
      inj_mask_d  = inj_mask;
    end
    ce_sum = {1'b0, ce_q} + 17'(rd_ce) + 17'(wr_ce);
    ue_sum = {1'b0, ue_q} + 17'(rd_ue) + 17'(wr_ue);
    ce_d   = ce_sum[16] ? 16'hFFFF : ce_sum[15:0];
    ue_d   = ue_sum[16] ? 16'hFFFF : ue_sum[15:0];
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wst_q       <= W_IDLE;
      rst_q       <= R_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rd_issued_q <= 1'b0;
      inj_armed_q <= 1'b0;
      ce_q        <= '0;
      ue_q        <= '0;
    end else begin
      wst_q       <= wst_d;
      rst_q       <= rst_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rd_issued_q <= rd_issued_d;
      inj_armed_q <= inj_armed_d;
      ce_q        <= ce_d;
      ue_q        <= ue_d;
    end
  end

  always_ff @(posedge aclk) begin
    awaddr_q   <= awaddr_d;
    awid_q     <= awid_d;
    wdata_q    <= wdata_d;
    wstrb_q    <= wstrb_d;
    araddr_q   <= araddr_d;
    arid_q     <= arid_d;
    inj_mask_q <= inj_mask_d;
  end

  axicb_ecc_ram #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (IDX_W),
    .WIDTH  (ECC_CW_W)
  ) u_ram (
    .clk   (aclk),
    .en    (wr_own ? ((wst_q == W_RMW) || wr_we) : rd_req),
    .we    (wr_own && wr_we),
    .addr  (wr_own ? addr_idx(awaddr_q) : rd_addr),
    .wdata (wr_cw),
    .rdata (ram_rdata)
  );

  assign awready = (wst_q == W_IDLE) && !aw_held_q;
  assign wready  = (wst_q == W_IDLE) && !w_held_q;
  assign bvalid  = (wst_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = (rst_q == R_IDLE);
  assign rvalid  = (rst_q == R_RESP);
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign ce_cnt  = ce_q;
  assign ue_cnt  = ue_q;

endmodule
`default_nettype wire

// File: tb/tb_axicb_ecc_slv_responder.sv
`default_nettype none
`timescale 1ns/1ps
// tb_axicb_ecc_slv_responder -- directed vector table plus hand sequences for the responder.
// Rev 1.0
module tb_axicb_ecc_slv_responder;

  logic        aclk = 1'b0;
  logic        srst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, inj_valid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awid, arid, bid, rid;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [38:0] inj_mask;
  logic [15:0] ce_cnt, ue_cnt;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axicb_ecc_slv_responder #(
    .AXI_ADDR_W (32),
    .AXI_ID_W   (8),
    .MEM_DEPTH  (64),
    .BASE_ADDR  (32'h0)
  ) dut (
    .aclk(aclk), .srst(srst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .inj_valid(inj_valid), .inj_mask(inj_mask),
    .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [38:0] inj;
    logic [1:0]  resp;
    logic [31:0] exp_data;
    bit          chk_data;
    int          lat;
    logic [15:0] ce;
    logic [15:0] ue;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [38:0] inj,
                              logic [1:0] resp, logic [31:0] ed, bit cd, int lat, logic [15:0] ce,
                              logic [15:0] ue);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.inj = inj; v.resp = resp;
    v.exp_data = ed; v.chk_data = cd; v.lat = lat; v.ce = ce; v.ue = ue;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic inject(input logic [38:0] m);
    inj_valid = 1'b1;
    inj_mask  = m;
    tick();
    inj_valid = 1'b0;
  endtask

  // lat = clock edges after the handshake edge until bvalid is seen (N+2 -> 1, N+3 -> 2)
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [7:0] id, output logic [1:0] resp, output logic [7:0] id_o,
                           output int lat);
    bit aw_done, w_done;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    awvalid = 1'b1; awaddr = a; awid = id;
    wvalid  = 1'b1; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && n < 20) begin
      logic aw_hs, w_hs;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    check("write_bvalid_timeout", {63'b0, bvalid}, 64'd1);
    resp = bresp; id_o = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [7:0] id, output logic [1:0] resp,
                          output logic [31:0] d, output logic [7:0] id_o, output int lat);
    int n;
    n = 0;
    arvalid = 1'b1; araddr = a; arid = id;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    check("read_rvalid_timeout", {63'b0, rvalid}, 64'd1);
    resp = rresp; d = rdata; id_o = rid;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {61'b0, awready, wready, arready}, 64'h7);
    check({tag, "_valid"}, {62'b0, bvalid, rvalid}, 64'h0);
    check({tag, "_resp_id"}, {44'b0, bresp, rresp, bid, rid}, 64'h0);
    check({tag, "_rdata"}, {32'b0, rdata}, 64'h0);
    check({tag, "_cnt"}, {32'b0, ce_cnt, ue_cnt}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [7:0]  id_o;
    int          lat;
    bit          stable;

    srst = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; rready = 0; inj_valid = 0; inj_mask = 0;
    tick(); tick();
    srst = 1'b0;
    check_reset_state("reset");

    //          wr  addr       data          strb  inj          resp   exp_data      chk lat ce ue
    vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 4'hF, 39'h0,     2'b00, 32'h0,        0,  1, 0, 0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        4'h0, 39'h0,     2'b00, 32'hDEADBEEF, 1,  1, 0, 0));
    vecs.push_back(mk(1, 32'h20,  32'h12345678, 4'hF, 39'h20,    2'b00, 32'h0,        0,  1, 0, 0));
    vecs.push_back(mk(0, 32'h20,  32'h0,        4'h0, 39'h0,     2'b00, 32'h12345678, 1,  1, 1, 0));
    vecs.push_back(mk(1, 32'h24,  32'hCAFEF00D, 4'hF, 39'h20008, 2'b00, 32'h0,        0,  1, 1, 0));
    vecs.push_back(mk(0, 32'h24,  32'h0,        4'h0, 39'h0,     2'b10, 32'h0,        0,  1, 1, 1));
    vecs.push_back(mk(1, 32'h24,  32'h00000055, 4'h1, 39'h0,     2'b10, 32'h0,        0,  2, 1, 2));
    vecs.push_back(mk(0, 32'h24,  32'h0,        4'h0, 39'h0,     2'b10, 32'h0,        0,  1, 1, 3));
    vecs.push_back(mk(1, 32'h30,  32'hAABBCCDD, 4'hF, 39'h0,     2'b00, 32'h0,        0,  1, 1, 3));
    vecs.push_back(mk(1, 32'h30,  32'h00001100, 4'h2, 39'h0,     2'b00, 32'h0,        0,  2, 1, 3));
    vecs.push_back(mk(0, 32'h30,  32'h0,        4'h0, 39'h0,     2'b00, 32'hAABB11DD, 1,  1, 1, 3));
    vecs.push_back(mk(1, 32'h30,  32'hFFFFFFFF, 4'h0, 39'h0,     2'b00, 32'h0,        0,  2, 1, 3));
    vecs.push_back(mk(0, 32'h33,  32'h0,        4'h0, 39'h0,     2'b00, 32'hAABB11DD, 1,  1, 1, 3));
    vecs.push_back(mk(1, 32'h00,  32'h11223344, 4'hF, 39'h0,     2'b00, 32'h0,        0,  1, 1, 3));
    vecs.push_back(mk(0, 32'h100, 32'h0,        4'h0, 39'h0,     2'b11, 32'h0,        1, -1, 1, 3));
    vecs.push_back(mk(1, 32'h100, 32'h99999999, 4'hF, 39'h0,     2'b11, 32'h0,        0, -1, 1, 3));
    vecs.push_back(mk(0, 32'h00,  32'h0,        4'h0, 39'h0,     2'b00, 32'h11223344, 1,  1, 1, 3));
    vecs.push_back(mk(1, 32'hFC,  32'h13579BDF, 4'hF, 39'h0,     2'b00, 32'h0,        0,  1, 1, 3));
    vecs.push_back(mk(0, 32'hFC,  32'h0,        4'h0, 39'h0,     2'b00, 32'h13579BDF, 1,  1, 1, 3));
    vecs.push_back(mk(0, 32'h20,  32'h0,        4'h0, 39'h0,     2'b00, 32'h12345678, 1,  1, 2, 3));
    vecs.push_back(mk(1, 32'h20,  32'h9A000000, 4'h8, 39'h0,     2'b00, 32'h0,        0,  2, 3, 3));
    vecs.push_back(mk(0, 32'h20,  32'h0,        4'h0, 39'h0,     2'b00, 32'h9A345678, 1,  1, 3, 3));

    foreach (vecs[i]) begin
      logic [7:0] id;
      id = 8'(i + 1);
      if (vecs[i].inj != '0) inject(vecs[i].inj);
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, id, resp, id_o, lat);
        d = 32'h0;
      end else begin
        axi_read(vecs[i].addr, id, resp, d, id_o, lat);
      end
      check($sformatf("v%0d_resp", i), {62'b0, resp}, {62'b0, vecs[i].resp});
      check($sformatf("v%0d_id", i), {56'b0, id_o}, {56'b0, id});
      if (vecs[i].chk_data) check($sformatf("v%0d_data", i), {32'b0, d}, {32'b0, vecs[i].exp_data});
      if (vecs[i].lat >= 0) check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_ce", i), {48'b0, ce_cnt}, {48'b0, vecs[i].ce});
      check($sformatf("v%0d_ue", i), {48'b0, ue_cnt}, {48'b0, vecs[i].ue});
    end

    // W three cycles ahead of AW, then a stalled B channel
    wvalid = 1'b1; wdata = 32'h5A5AA5A5; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    check("early_w_wready_drop", {63'b0, wready}, 64'd0);
    check("early_w_awready", {63'b0, awready}, 64'd1);
    tick(); tick();
    awvalid = 1'b1; awaddr = 32'h44; awid = 8'hC3;
    tick();
    awvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    check("early_w_lat", 64'(lat), 64'd1);
    check("early_w_bid", {56'b0, bid}, 64'hC3);
    check("early_w_bresp", {62'b0, bresp}, 64'd0);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (!bvalid || bid !== 8'hC3 || bresp !== 2'b00) stable = 1'b0;
    end
    check("bvalid_stable", {63'b0, stable}, 64'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done_idle", {61'b0, bvalid, awready, wready}, 64'h3);
    axi_read(32'h44, 8'h44, resp, d, id_o, lat);
    check("early_w_readback", {32'b0, d}, 64'h5A5AA5A5);

    // read accepted while the write FSM is in W_WRITE: one stall cycle, new data returned
    bready = 1'b1;
    awvalid = 1'b1; awaddr = 32'h40; awid = 8'h11;
    wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h40; arid = 8'h22;
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    check("conflict_lat", 64'(lat), 64'd2);
    check("conflict_rdata", {32'b0, rdata}, 64'h0BADF00D);
    check("conflict_rid", {56'b0, rid}, 64'h22);
    rready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;

    // reset during R_READ with injection armed
    inject(39'h400);
    arvalid = 1'b1; araddr = 32'h10; arid = 8'h33;
    tick();
    arvalid = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_reset_state("midreset");
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rvalid) stable = 1'b0;
    end
    check("no_rvalid_after_reset", {63'b0, stable}, 64'd1);
    axi_write(32'h50, 32'hDEADC0DE, 4'hF, 8'h55, resp, id_o, lat);
    axi_read(32'h50, 8'h56, resp, d, id_o, lat);
    check("inj_disarmed_data", {32'b0, d}, 64'hDEADC0DE);
    check("inj_disarmed_ce", {48'b0, ce_cnt}, 64'd0);
    axi_read(32'h10, 8'h57, resp, d, id_o, lat);
    check("mem_kept_over_reset", {32'b0, d}, 64'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
